// File: rtl/add_accum32.sv
// ---------------------------------------------------------------------------
// add_accum32 -- streaming multi-operand accumulator.
//
// Adds a stream of two's-complement operands into a running sum under a
// valid/ready handshake. The beat carrying in_last closes the group: the
// block enters HOLD and presents the sum, carry count, sticky signed-overflow
// flag and operand count until the consumer accepts them. The accepting
// handshake clears all state and returns the block to ACC.
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous, active-high reset
//   in_valid      operand beat present
//   in_ready      block can accept an operand (ACC state and not in reset)
//   in_data       operand, two's complement, WIDTH bits
//   in_last       marks the final operand of a group
//   out_valid     group result present (HOLD state)
//   out_ready     consumer accepts the result
//   out_sum       group sum mod 2^WIDTH
//   out_carries   accumulate steps with carry out of the MSB, saturating
//   out_overflow  sticky signed-overflow flag
//   out_count     operands in the group, saturating
// ---------------------------------------------------------------------------
module add_accum32 #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic [CNT_W-1:0] out_carries,
  output logic             out_overflow,
  output logic [CNT_W-1:0] out_count
);

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]   carries_q, carries_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ovf_q, ovf_d;

  logic               accept;
  logic [WIDTH:0]     step_res;
  logic               step_ovf;

  // Handshake signals are decoded straight from the state register; in_ready
  // is additionally gated by rst so nothing is taken while reset is held.
  assign in_ready  = (state_q == ACC) & ~rst;
  assign out_valid = (state_q == HOLD);
  assign accept    = in_valid & in_ready;

  // One extra bit on the adder captures the carry out of the MSB.
  assign step_res = {1'b0, sum_q} + {1'b0, in_data};

  // Signed overflow: both addends share a sign and the result's sign differs.
  assign step_ovf = (sum_q[WIDTH-1] == in_data[WIDTH-1]) &
                    (step_res[WIDTH-1] != in_data[WIDTH-1]);

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path through
    // the case statement leaves one unassigned (which would infer a latch).
    state_d   = state_q;
    sum_d     = sum_q;
    carries_d = carries_q;
    count_d   = count_q;
    ovf_d     = ovf_q;

    unique case (state_q)
      ACC: begin
        if (accept) begin
          sum_d = step_res[WIDTH-1:0];
          if (step_res[WIDTH] && (carries_q != '1))
            carries_d = carries_q + CNT_W'(1);
          if (count_q != '1)
            count_d = count_q + CNT_W'(1);
          ovf_d = ovf_q | step_ovf;
          if (in_last)
            state_d = HOLD;
        end
      end
      HOLD: begin
        // Result stays frozen until the consumer takes it; then start clean.
        if (out_ready) begin
          sum_d     = '0;
          carries_d = '0;
          count_d   = '0;
          ovf_d     = 1'b0;
          state_d   = ACC;
        end
      end
      default: state_d = ACC;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its inputs, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ACC;
      sum_q     <= '0;
      carries_q <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sum_q     <= sum_d;
      carries_q <= carries_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
    end
  end

  assign out_sum      = sum_q;
  assign out_carries  = carries_q;
  assign out_overflow = ovf_q;
  assign out_count    = count_q;

endmodule

// File: tb/tb_add_accum32.sv
// ---------------------------------------------------------------------------
// tb_add_accum32 -- directed self-checking bench for add_accum32.
// Inputs change and outputs are sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_add_accum32;

  localparam int WIDTH = 32;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_sum;
  logic [CNT_W-1:0] out_carries;
  logic             out_overflow;
  logic [CNT_W-1:0] out_count;

  int checks = 0;
  int errors = 0;

  add_accum32 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sum      (out_sum),
    .out_carries  (out_carries),
    .out_overflow (out_overflow),
    .out_count    (out_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until accepted (bounded wait on in_ready).
  task automatic push(input logic [31:0] d, input logic last);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    if (!in_ready) check("push_timeout", 64'(0), 64'(1));
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
  endtask

  // Wait (bounded) for a result, compare it, then complete the handshake.
  task automatic expect_result(input string tag, input logic [31:0] s,
                               input logic [7:0] c, input logic o,
                               input logic [7:0] n);
    int   k;
    logic keep_ready;
    k = 0;
    while (!out_valid && k < 20) begin
      step();
      k++;
    end
    check({tag, "_valid"},    64'(out_valid),    64'(1));
    check({tag, "_sum"},      64'(out_sum),      64'(s));
    check({tag, "_carries"},  64'(out_carries),  64'(c));
    check({tag, "_overflow"}, 64'(out_overflow), 64'(o));
    check({tag, "_count"},    64'(out_count),    64'(n));
    keep_ready = out_ready;
    out_ready  = 1'b1;
    step();
    out_ready  = keep_ready;
    check({tag, "_released"}, 64'(out_valid), 64'(0));
  endtask

  initial begin
    // Reset state.
    #2;
    check("rst_in_ready",  64'(in_ready),     64'(0));
    check("rst_out_valid", 64'(out_valid),    64'(0));
    check("rst_sum",       64'(out_sum),      64'(0));
    check("rst_count",     64'(out_count),    64'(0));
    check("rst_carries",   64'(out_carries),  64'(0));
    check("rst_overflow",  64'(out_overflow), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rel_in_ready", 64'(in_ready), 64'(1));

    // Back-to-back groups with out_ready held high.
    out_ready = 1'b1;
    push(32'h7fffffff, 1'b0); push(32'h00000001, 1'b1);
    expect_result("g_posovf", 32'h80000000, 8'd0, 1'b1, 8'd2);
    push(32'hffffffff, 1'b0); push(32'h80000000, 1'b1);
    expect_result("g_negovf", 32'h7fffffff, 8'd1, 1'b1, 8'd2);
    push(32'h00000002, 1'b0); push(32'hfffffffb, 1'b1);
    expect_result("g_mixed", 32'hfffffffd, 8'd0, 1'b0, 8'd2);
    push(32'h0000000c, 1'b0); push(32'h00000019, 1'b1);
    expect_result("g_small", 32'h00000025, 8'd0, 1'b0, 8'd2);
    push(32'hfffffffb, 1'b0); push(32'hfffffff4, 1'b1);
    expect_result("g_negcarry", 32'hffffffef, 8'd1, 1'b0, 8'd2);

    // Backpressure with junk data offered during HOLD.
    out_ready = 1'b0;
    push(32'h00000007, 1'b0); push(32'h00000008, 1'b1);
    in_valid = 1'b1; in_data = 32'hdeadbeef; in_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("bp_valid",    64'(out_valid), 64'(1));
      check("bp_sum",      64'(out_sum),   64'(32'h0000000f));
      check("bp_count",    64'(out_count), 64'(2));
      check("bp_in_ready", 64'(in_ready),  64'(0));
      step();
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    out_ready = 1'b0;
    check("bp_done_valid", 64'(out_valid), 64'(0));
    check("bp_cleared_sum",   64'(out_sum),   64'(0));
    check("bp_cleared_count", 64'(out_count), 64'(0));
    push(32'h0000000a, 1'b1);
    expect_result("g_single", 32'h0000000a, 8'd0, 1'b0, 8'd1);

    // Saturation of carry and operand counters.
    out_ready = 1'b1;
    for (int i = 0; i < 300; i++) push(32'hffffffff, (i == 299));
    expect_result("g_sat", 32'hfffffed4, 8'hff, 1'b0, 8'hff);

    // Asynchronous reset in the middle of a group.
    push(32'h00000005, 1'b0); push(32'h00000006, 1'b0);
    check("mid_partial_sum", 64'(out_sum), 64'(32'h0000000b));
    #2 rst = 1'b1;
    #1;
    check("mid_rst_sum",      64'(out_sum),   64'(0));
    check("mid_rst_count",    64'(out_count), 64'(0));
    check("mid_rst_in_ready", 64'(in_ready),  64'(0));
    check("mid_rst_valid",    64'(out_valid), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rel_in_ready", 64'(in_ready), 64'(1));
    push(32'h00000003, 1'b0); push(32'h00000004, 1'b1);
    expect_result("g_after_rst", 32'h00000007, 8'd0, 1'b0, 8'd2);

    // Asynchronous reset while a result is held.
    out_ready = 1'b0;
    push(32'h00000009, 1'b1);
    check("hold_valid", 64'(out_valid), 64'(1));
    #2 rst = 1'b1;
    #1;
    check("hold_rst_valid", 64'(out_valid), 64'(0));
    check("hold_rst_sum",   64'(out_sum),   64'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;

    // Idle gaps between beats.
    out_ready = 1'b1;
    push(32'h00000001, 1'b0);
    step(); step();
    check("gap_count", 64'(out_count), 64'(1));
    check("gap_sum",   64'(out_sum),   64'(1));
    push(32'h00000002, 1'b0);
    in_last = 1'b1;  // last without valid must be ignored
    step(); step();
    in_last = 1'b0;
    check("gap_last_ignored", 64'(out_valid), 64'(0));
    push(32'h00000003, 1'b1);
    expect_result("g_gaps", 32'h00000006, 8'd0, 1'b0, 8'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/add_accum32.md
# add_accum32

Streaming multi-operand accumulator that sits directly downstream of the 32-bit adder family. It accepts a stream of 32-bit two's-complement operands under a valid/ready handshake and adds each one into a running sum. On the last operand of a group it presents the registered sum, carry-out count, sticky signed-overflow flag and operand count, and holds them until the consumer accepts.

## Interface
Parameters:
- WIDTH, 32, operand and sum width in bits
- CNT_W, 8, width of the operand-count and carry-count fields (both saturate)

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand beat present
- in_ready  out  1  block can accept an operand this cycle
- in_data  in  WIDTH  operand, two's complement
- in_last  in  1  qualifies the beat as the final operand of a group
- out_valid  out  1  group result present
- out_ready  in  1  consumer accepts the result
- out_sum  out  WIDTH  group sum mod 2^WIDTH
- out_carries  out  CNT_W  number of accumulate steps that produced a carry out of bit WIDTH-1, saturating
- out_overflow  out  1  sticky: at least one accumulate step overflowed in the signed sense
- out_count  out  CNT_W  operands in the group, saturating

## Operation
- Two states: ACC and HOLD. Reset state is ACC.
- Reset (async) clears sum, carries, count and overflow to 0, sets out_valid=0, and moves the block to ACC.
- in_ready = (state==ACC) & ~rst. out_valid = (state==HOLD).
- In ACC, an accept occurs on in_valid & in_ready. On each accept:
  - sum <= sum + in_data, computed with a WIDTH+1 bit result.
  - Bit WIDTH of that result is the step carry. If the carry is 1, carries increments, saturating at 2^CNT_W-1.
  - overflow |= (sum[W-1]==in_data[W-1]) & (new_sum[W-1]!=in_data[W-1]).
  - count increments, saturating at 2^CNT_W-1.
- If in_last is set on an accepted beat, that beat is included in the result and the state goes to HOLD. A single-operand group is legal.
- in_last without in_valid is ignored.
- In HOLD:
  - in_ready=0; in_valid and in_data are ignored.
  - out_* stay stable until out_valid & out_ready.
  - On that handshake, sum, carries, count and overflow clear to 0 and the state returns to ACC.
- While in ACC, out_* reflect the running registers, but consumers must qualify them with out_valid.
- Sum wraps mod 2^WIDTH. Saturation of the counters never affects the sum.

## Timing
- Accept-to-register latency is 1 cycle. out_valid rises on the edge that accepts the last beat.
- Minimum gap between groups is 1 cycle: the output handshake edge returns the block to ACC, and in_ready is high in the next cycle.
- Throughput is 1 operand per cycle in ACC.
- out_ready held high while in HOLD → out_valid is high for exactly 1 cycle.
- Reset asserted mid-group or during HOLD:
  - The partial group or the held result is discarded immediately (async).
  - out_valid=0 and in_ready=0 while rst=1.
  - in_ready=1 on the first cycle after release.
- All outputs are registered except in_ready and out_valid, which are decoded from the state register.

## Test plan
- Groups driven back-to-back, out_ready=1 throughout:
  - {7fffffff, 1} -> sum 80000000, carries 0, overflow 1, count 2
  - {ffffffff, 80000000} -> sum 7fffffff, carries 1, overflow 1, count 2
  - {2, fffffffb} -> sum fffffffd, carries 0, overflow 0, count 2
- Groups {c, 19} -> sum 25, carries 0, overflow 0, count 2; {fffffffb, fffffff4} -> sum ffffffef, carries 1, overflow 0, count 2; single-beat group {a} -> sum a, count 1.
- Backpressure: {7, 8} with out_ready=0 for 3 cycles and in_valid held high with junk data -> out_sum f is stable, in_ready=0, and the junk is not absorbed. Raising out_ready completes the handshake, and the next group starts from 0.
- Saturation: 300 beats of ffffffff, last on beat 300 -> sum fffffed4, carries ff (299 saturated), count ff, overflow 0.
- Reset mid-group: accept {5, 6}, then pulse rst asynchronously between edges -> out_valid=0 at once. The next group {3, 4(last)} -> sum 7, count 2, carries 0, overflow 0.
- Idle gaps: group {1, 2, 3(last)} with in_valid low for 2 cycles between beats -> sum 6, count 3; no extra accumulation during the gaps.
